// File: rtl/uint_sub_skid_stage.sv
// Registered valid/ready subtract stage: O = I0 - I1 (mod 2^width), borrow = (I1 > I0).
// Results sit in a 2-entry skid buffer (main entry drives outputs, skid entry absorbs a stall).
// A saturating counter tracks accepted pairs that borrowed.
// Optional build macro UINT_SUB_SAT_EN: on borrow the stored O is clamped to zero.
module uint_sub_skid_stage #(
  parameter int unsigned width     = 3,
  parameter int unsigned cnt_width = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     I0,
  input  logic [width-1:0]     I1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     O,
  output logic                 borrow,
  output logic [cnt_width-1:0] borrow_count
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               state_q, state_d;
  logic [width-1:0]     main_o_q, main_o_d;
  logic                 main_b_q, main_b_d;
  logic [width-1:0]     skid_o_q, skid_o_d;
  logic                 skid_b_q, skid_b_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;

  logic [width-1:0] diff;
  logic [width-1:0] new_o;
  logic             new_b;
  logic             accept;
  logic             pop;

  // Result of the incoming pair, captured into whichever entry the FSM selects.
  always_comb begin
    diff  = I0 - I1;
    new_b = (I1 > I0);
`ifdef UINT_SUB_SAT_EN
    new_o = new_b ? '0 : diff;
`else
    new_o = diff;
`endif
  end

  // Handshake flags decode straight from the state register, so no in->out comb path.
  always_comb begin
    in_ready     = (state_q != StFull);
    out_valid    = (state_q != StEmpty);
    O            = main_o_q;
    borrow       = main_b_q;
    borrow_count = cnt_q;
    accept       = in_valid & in_ready;
    pop          = out_valid & out_ready;
  end

  // Skid-buffer FSM: next state and entry updates.
  always_comb begin
    state_d  = state_q;
    main_o_d = main_o_q;
    main_b_d = main_b_q;
    skid_o_d = skid_o_q;
    skid_b_d = skid_b_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_o_d = new_o;
          main_b_d = new_b;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_o_d = new_o;
          main_b_d = new_b;
        end else if (accept) begin
          skid_o_d = new_o;
          skid_b_d = new_b;
          state_d  = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          main_o_d = skid_o_q;
          main_b_d = skid_b_q;
          state_d  = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Borrow counter counts at accept time and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && new_b && (cnt_q != {cnt_width{1'b1}})) begin
      cnt_d = cnt_q + cnt_width'(1);
    end
  end

  // State and storage registers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q  <= StEmpty;
      main_o_q <= '0;
      main_b_q <= 1'b0;
      skid_o_q <= '0;
      skid_b_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      main_o_q <= main_o_d;
      main_b_q <= main_b_d;
      skid_o_q <= skid_o_d;
      skid_b_q <= skid_b_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
